// File: rtl/fetch_pc_unit.sv
// Program counter and fetch control for the single-cycle CPU: run/step/halt
// sequencing, branch resolution, commit strobe and retired-instruction count.
module fetch_pc_unit #(
    parameter logic [7:0]  PC_RESET = 8'h00,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [15:0]      INSTR,
    input  logic [15:0]      RS_DATA,
    input  logic [15:0]      RT_DATA,
    output logic [7:0]       ADDR,
    output logic             ADV,
    output logic             BR_TAKEN,
    output logic             HALTED,
    output logic [CNT_W-1:0] RETIRED
);

    localparam int unsigned PC_W  = 8;
    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OPC_BEQ  = 4'b1000;
    localparam logic [OPC_W-1:0] OPC_BNE  = 4'b1001;
    localparam logic [OPC_W-1:0] OPC_BGEZ = 4'b1010;
    localparam logic [OPC_W-1:0] OPC_BLTZ = 4'b1011;

    logic [PC_W-1:0]  pc;
    logic             halted;
    logic [CNT_W-1:0] retired;
    logic             step_q;

    logic             step_edge;
    logic             req;
    logic             is_halt_word;
    logic             adv;
    logic             br_cond;
    logic             taken;
    logic [PC_W-1:0]  br_offset;
    logic [PC_W-1:0]  next_pc;
    logic             retired_max;

    // Request qualification: held STEP produces only one rising-edge request
    assign step_edge    = STEP & ~step_q;
    assign req          = RUN | step_edge;
    assign is_halt_word = (INSTR == 16'h0000);
    assign adv          = ~RESET & ~halted & req & ~is_halt_word;

    // Branch condition from opcode and register read data
    always_comb begin
        br_cond = 1'b0;
        unique case (INSTR[15:12])
            OPC_BEQ:  br_cond = (RS_DATA == RT_DATA);
            OPC_BNE:  br_cond = (RS_DATA != RT_DATA);
            OPC_BGEZ: br_cond = ~RS_DATA[15];
            OPC_BLTZ: br_cond = RS_DATA[15];
            default:  br_cond = 1'b0;
        endcase
    end

    assign taken = adv & br_cond;

    // Word offset, sign-extended and scaled to bytes; relative to the branch itself
    assign br_offset = {INSTR[5], INSTR[5:0], 1'b0};
    assign next_pc   = taken ? (pc + br_offset) : (pc + PC_W'(2));

    assign retired_max = (retired == {CNT_W{1'b1}});

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc      <= PC_RESET;
            halted  <= 1'b0;
            retired <= '0;
            step_q  <= 1'b0;
        end else begin
            step_q <= STEP;
            if (adv) begin
                pc <= next_pc;
            end
            if (adv && !retired_max) begin
                retired <= retired + CNT_W'(1);
            end
            if (!halted && req && is_halt_word) begin
                halted <= 1'b1;
            end
        end
    end

    assign ADDR     = pc;
    assign ADV      = adv;
    assign BR_TAKEN = taken;
    assign HALTED   = halted;
    assign RETIRED  = retired;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; the bench models the instruction RAM
// and checks PC sequencing, branches, stepping, halt, wrap and saturation.
module tb_fetch_pc_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RUN;
    logic        STEP;
    logic [15:0] INSTR;
    logic [15:0] RS_DATA;
    logic [15:0] RT_DATA;
    logic [7:0]  ADDR;
    logic        ADV;
    logic        BR_TAKEN;
    logic        HALTED;
    logic [15:0] RETIRED;

    logic [7:0]  addr4;
    logic        adv4;
    logic        br_taken4;
    logic        halted4;
    logic [3:0]  retired4;

    logic [15:0] mem [128];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign INSTR = mem[ADDR[7:1]];

    fetch_pc_unit dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RUN      (RUN),
        .STEP     (STEP),
        .INSTR    (INSTR),
        .RS_DATA  (RS_DATA),
        .RT_DATA  (RT_DATA),
        .ADDR     (ADDR),
        .ADV      (ADV),
        .BR_TAKEN (BR_TAKEN),
        .HALTED   (HALTED),
        .RETIRED  (RETIRED)
    );

    // Narrow-counter build sharing the same stimulus, for saturation
    fetch_pc_unit #(.CNT_W(4)) dut4 (
        .CLK      (CLK),
        .RESET    (RESET),
        .RUN      (RUN),
        .STEP     (STEP),
        .INSTR    (INSTR),
        .RS_DATA  (RS_DATA),
        .RT_DATA  (RT_DATA),
        .ADDR     (addr4),
        .ADV      (adv4),
        .BR_TAKEN (br_taken4),
        .HALTED   (halted4),
        .RETIRED  (retired4)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_nops();
        for (int i = 0; i < 128; i++) mem[i] = 16'h1001;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        RUN   = 1'b0;
        STEP  = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        fill_nops();
        RS_DATA = 16'h0000;
        RT_DATA = 16'h0000;
        RESET = 1'b1;
        RUN   = 1'b1;
        STEP  = 1'b1;
        #1;
        checks++;
        if (ADV !== 1'b0 || BR_TAKEN !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: ADV=%b BR_TAKEN=%b expected 0 0", ADV, BR_TAKEN);
        end
        tick();
        checks++;
        if (ADDR !== 8'h00 || HALTED !== 1'b0 || RETIRED !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: ADDR=%h HALTED=%b RETIRED=%0d expected 00 0 0",
                     ADDR, HALTED, RETIRED);
        end
        RESET = 1'b0;
        RUN   = 1'b0;
        STEP  = 1'b0;
        tick();
        checks++;
        if (ADDR !== 8'h00 || RETIRED !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle: ADDR=%h RETIRED=%0d expected 00 0", ADDR, RETIRED);
        end
    endtask

    task automatic test_run_halt();
        fill_nops();
        mem[0] = 16'h1001;
        mem[1] = 16'h2002;
        mem[2] = 16'h3003;
        mem[3] = 16'h4004;
        mem[4] = 16'h0000;
        apply_reset();
        RUN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ADDR !== 8'(2 * i) || ADV !== 1'b1) begin
                errors++;
                $display("FAIL run_seq[%0d]: ADDR=%h ADV=%b expected %h 1", i, ADDR, ADV, 8'(2 * i));
            end
            tick();
        end
        #1;
        checks++;
        if (ADDR !== 8'h08 || ADV !== 1'b0 || HALTED !== 1'b0) begin
            errors++;
            $display("FAIL halt_fetch: ADDR=%h ADV=%b HALTED=%b expected 08 0 0", ADDR, ADV, HALTED);
        end
        tick();
        checks++;
        if (ADDR !== 8'h08 || HALTED !== 1'b1 || RETIRED !== 16'd4) begin
            errors++;
            $display("FAIL halt_entry: ADDR=%h HALTED=%b RETIRED=%0d expected 08 1 4",
                     ADDR, HALTED, RETIRED);
        end
        tick();
        tick();
        checks++;
        if (ADDR !== 8'h08 || ADV !== 1'b0 || HALTED !== 1'b1 || RETIRED !== 16'd4) begin
            errors++;
            $display("FAIL halt_hold: ADDR=%h ADV=%b HALTED=%b RETIRED=%0d expected 08 0 1 4",
                     ADDR, ADV, HALTED, RETIRED);
        end
    endtask

    task automatic test_branch_bne();
        fill_nops();
        mem[17] = 16'h91F8;
        RS_DATA = 16'd0;
        RT_DATA = 16'd5;
        apply_reset();
        RUN = 1'b1;
        repeat (17) tick();
        #1;
        checks++;
        if (ADDR !== 8'h22 || BR_TAKEN !== 1'b1 || ADV !== 1'b1) begin
            errors++;
            $display("FAIL bne_taken: ADDR=%h BR_TAKEN=%b ADV=%b expected 22 1 1", ADDR, BR_TAKEN, ADV);
        end
        tick();
        checks++;
        if (ADDR !== 8'h12) begin
            errors++;
            $display("FAIL bne_target: ADDR=%h expected 12", ADDR);
        end
        RT_DATA = 16'd0;
        repeat (8) tick();
        #1;
        checks++;
        if (ADDR !== 8'h22 || BR_TAKEN !== 1'b0 || ADV !== 1'b1) begin
            errors++;
            $display("FAIL bne_not_taken: ADDR=%h BR_TAKEN=%b ADV=%b expected 22 0 1", ADDR, BR_TAKEN, ADV);
        end
        tick();
        checks++;
        if (ADDR !== 8'h24 || RETIRED !== 16'd27) begin
            errors++;
            $display("FAIL bne_fallthru: ADDR=%h RETIRED=%0d expected 24 27", ADDR, RETIRED);
        end
    endtask

    task automatic test_branch_sign();
        fill_nops();
        mem[31] = 16'hA817;
        mem[55] = 16'hB002;
        RS_DATA = 16'h7FFF;
        RT_DATA = 16'h0000;
        apply_reset();
        RUN = 1'b1;
        repeat (31) tick();
        #1;
        checks++;
        if (ADDR !== 8'h3E || BR_TAKEN !== 1'b1) begin
            errors++;
            $display("FAIL bgez_taken: ADDR=%h BR_TAKEN=%b expected 3e 1", ADDR, BR_TAKEN);
        end
        tick();
        checks++;
        if (ADDR !== 8'h6C) begin
            errors++;
            $display("FAIL bgez_target: ADDR=%h expected 6c", ADDR);
        end
        RS_DATA = 16'hFFF9;
        tick();
        #1;
        checks++;
        if (ADDR !== 8'h6E || BR_TAKEN !== 1'b1) begin
            errors++;
            $display("FAIL bltz_taken: ADDR=%h BR_TAKEN=%b expected 6e 1", ADDR, BR_TAKEN);
        end
        tick();
        checks++;
        if (ADDR !== 8'h72) begin
            errors++;
            $display("FAIL bltz_target: ADDR=%h expected 72", ADDR);
        end
        RS_DATA = 16'h8000;
        apply_reset();
        RUN = 1'b1;
        repeat (31) tick();
        #1;
        checks++;
        if (ADDR !== 8'h3E || BR_TAKEN !== 1'b0 || ADV !== 1'b1) begin
            errors++;
            $display("FAIL bgez_not_taken: ADDR=%h BR_TAKEN=%b ADV=%b expected 3e 0 1", ADDR, BR_TAKEN, ADV);
        end
        tick();
        checks++;
        if (ADDR !== 8'h40) begin
            errors++;
            $display("FAIL bgez_fallthru: ADDR=%h expected 40", ADDR);
        end
    endtask

    task automatic test_single_step();
        int adv_count;
        fill_nops();
        apply_reset();
        adv_count = 0;
        for (int c = 0; c < 8; c++) begin
            STEP = (c < 5);
            #1;
            if (ADV === 1'b1) adv_count++;
            checks++;
            if (ADV !== (c == 0)) begin
                errors++;
                $display("FAIL step_hold[%0d]: ADV=%b expected %b", c, ADV, (c == 0));
            end
            tick();
        end
        STEP = 1'b1;
        #1;
        if (ADV === 1'b1) adv_count++;
        tick();
        STEP = 1'b0;
        #1;
        if (ADV === 1'b1) adv_count++;
        tick();
        checks++;
        if (adv_count != 2 || ADDR !== 8'h04 || RETIRED !== 16'd2) begin
            errors++;
            $display("FAIL step_count: advs=%0d ADDR=%h RETIRED=%0d expected 2 04 2",
                     adv_count, ADDR, RETIRED);
        end
    endtask

    task automatic test_back_to_back();
        // Continues from the single-step state: ADDR=04, RETIRED=2, STEP low
        RUN  = 1'b1;
        STEP = 1'b1;
        tick();
        STEP = 1'b0;
        tick();
        checks++;
        if (ADDR !== 8'h08 || RETIRED !== 16'd4) begin
            errors++;
            $display("FAIL run_and_step: ADDR=%h RETIRED=%0d expected 08 4", ADDR, RETIRED);
        end
        RUN = 1'b0;
        tick();
        tick();
        checks++;
        if (ADDR !== 8'h08 || RETIRED !== 16'd4 || ADV !== 1'b0) begin
            errors++;
            $display("FAIL pause: ADDR=%h RETIRED=%0d ADV=%b expected 08 4 0", ADDR, RETIRED, ADV);
        end
        RUN = 1'b1;
        tick();
        checks++;
        if (ADDR !== 8'h0A || RETIRED !== 16'd5) begin
            errors++;
            $display("FAIL resume: ADDR=%h RETIRED=%0d expected 0a 5", ADDR, RETIRED);
        end
    endtask

    task automatic test_wrap_saturate();
        fill_nops();
        RS_DATA = 16'h0000;
        RT_DATA = 16'h0000;
        apply_reset();
        RUN = 1'b1;
        repeat (14) tick();
        checks++;
        if (retired4 !== 4'hE) begin
            errors++;
            $display("FAIL sat_pre: RETIRED4=%h expected e", retired4);
        end
        repeat (6) tick();
        checks++;
        if (retired4 !== 4'hF || RETIRED !== 16'd20) begin
            errors++;
            $display("FAIL sat_20: RETIRED4=%h RETIRED=%0d expected f 20", retired4, RETIRED);
        end
        repeat (107) tick();
        checks++;
        if (ADDR !== 8'hFE || addr4 !== 8'hFE) begin
            errors++;
            $display("FAIL wrap_pre: ADDR=%h ADDR4=%h expected fe fe", ADDR, addr4);
        end
        tick();
        checks++;
        if (ADDR !== 8'h00 || RETIRED !== 16'd128 || retired4 !== 4'hF) begin
            errors++;
            $display("FAIL wrap: ADDR=%h RETIRED=%0d RETIRED4=%h expected 00 128 f",
                     ADDR, RETIRED, retired4);
        end
    endtask

    task automatic test_reset_mid();
        fill_nops();
        mem[17] = 16'h91F8;
        RS_DATA = 16'd0;
        RT_DATA = 16'd5;
        apply_reset();
        RUN = 1'b1;
        repeat (17) tick();
        RESET = 1'b1;
        #1;
        checks++;
        if (ADDR !== 8'h22 || ADV !== 1'b0 || BR_TAKEN !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_comb: ADDR=%h ADV=%b BR_TAKEN=%b expected 22 0 0", ADDR, ADV, BR_TAKEN);
        end
        tick();
        RESET = 1'b0;
        checks++;
        if (ADDR !== 8'h00 || RETIRED !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: ADDR=%h RETIRED=%0d expected 00 0", ADDR, RETIRED);
        end
        mem[2] = 16'h0000;
        tick();
        tick();
        tick();
        checks++;
        if (ADDR !== 8'h04 || HALTED !== 1'b1 || RETIRED !== 16'd2) begin
            errors++;
            $display("FAIL halt2: ADDR=%h HALTED=%b RETIRED=%0d expected 04 1 2", ADDR, HALTED, RETIRED);
        end
        mem[2] = 16'h1001;
        STEP = 1'b1;
        #1;
        checks++;
        if (ADV !== 1'b0) begin
            errors++;
            $display("FAIL halted_ignore: ADV=%b expected 0", ADV);
        end
        tick();
        STEP = 1'b0;
        checks++;
        if (ADDR !== 8'h04 || HALTED !== 1'b1) begin
            errors++;
            $display("FAIL halted_frozen: ADDR=%h HALTED=%b expected 04 1", ADDR, HALTED);
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++;
        if (ADDR !== 8'h00 || HALTED !== 1'b0 || RETIRED !== 16'd0) begin
            errors++;
            $display("FAIL reset_halted: ADDR=%h HALTED=%b RETIRED=%0d expected 00 0 0",
                     ADDR, HALTED, RETIRED);
        end
        tick();
        checks++;
        if (ADDR !== 8'h02 || RETIRED !== 16'd1) begin
            errors++;
            $display("FAIL restart: ADDR=%h RETIRED=%0d expected 02 1", ADDR, RETIRED);
        end
    endtask

    initial begin
        RESET   = 1'b1;
        RUN     = 1'b0;
        STEP    = 1'b0;
        RS_DATA = 16'h0000;
        RT_DATA = 16'h0000;
        fill_nops();
        test_reset();
        test_run_halt();
        test_branch_bne();
        test_branch_sign();
        test_single_step();
        test_back_to_back();
        test_wrap_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and fetch-control stage sitting directly upstream of the 16-bit instruction RAM.
- Drives the RAM's byte address (ADDR) and consumes its instruction word (Q → INSTR).
- Resolves the four conditional branches using register-file read data.
- Provides run/single-step/halt control and a commit strobe (ADV) that gates all architectural writes elsewhere in the single-cycle CPU.

Parameters:
- PC_RESET, 8'h00, byte address loaded into the PC on reset; must be even.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- RUN  in  1  level: free-run enable.
- STEP  in  1  single-step request; one instruction per 0→1 transition.
- INSTR  in  16  instruction word from instruction RAM for the current ADDR.
- RS_DATA  in  16  register-file read data for INSTR[11:9].
- RT_DATA  in  16  register-file read data for INSTR[8:6].
- ADDR  out  8  current PC (byte address, always even) to instruction RAM.
- ADV  out  1  combinational commit strobe: the current INSTR executes this cycle.
- BR_TAKEN  out  1  combinational: current INSTR is a taken branch (qualified by ADV).
- HALTED  out  1  registered: core stopped on HALT word.
- RETIRED  out  CNT_W  registered count of committed instructions.

Behaviour:
- Reset:
  - On any cycle with RESET=1: PC←PC_RESET, HALTED←0, RETIRED←0, step_q←0.
  - ADV=0 and BR_TAKEN=0 while RESET=1.
  - RESET overrides RUN, STEP and mid-instruction state. The instruction RAM loads its contents on the same reset cycles, so the first valid fetch is the first cycle after RESET deasserts.
- Step edge detection:
  - step_q is a register holding the previous STEP.
  - step_edge = STEP & ~step_q.
  - Holding STEP high yields exactly one step.
- Request: req = RUN | step_edge. RUN and step_edge together still give one instruction per cycle.
- HALT word: INSTR == 16'h0000 (unprogrammed RAM fill) is HALT.
- ADV:
  - ADV = ~RESET & ~HALTED & req & (INSTR != 0).
  - Latency 0: fetch, decode and commit all occur in the same cycle; the PC updates at the closing edge.
- Halt entry:
  - Condition: ~HALTED & req & INSTR==0.
  - Effect: HALTED←1, PC unchanged, RETIRED unchanged, ADV=0.
  - HALTED is sticky; only RESET clears it. While HALTED, RUN and STEP are ignored and PC is frozen.
- Branch decode on INSTR[15:12], with rs = RS_DATA, rt = RT_DATA, comparisons on 16-bit values:
  - 4'b1000 BEQ: taken if rs == rt.
  - 4'b1001 BNE: taken if rs != rt.
  - 4'b1010 BGEZ: taken if rs[15] == 0 (signed).
  - 4'b1011 BLTZ: taken if rs[15] == 1.
  - All other opcodes: not taken.
  - BR_TAKEN = ADV & condition.
- Next PC on an ADV cycle:
  - Taken: PC ← PC + {sext(INSTR[5:0]), 1'b0}. The offset is relative to the branch's own address, not PC+2.
  - Otherwise: PC ← PC + 2.
  - All arithmetic is modulo 256: 8'hFE+2 → 8'h00, and 8'h02 + (−4 words) → 8'hFA.
  - PC[0] stays 0.
- Non-ADV cycles (paused, halted, or halt entry): PC holds.
- RETIRED:
  - Increments by 1 on each ADV cycle.
  - Saturates at all-ones; no wrap.
- Pause/resume: dropping RUN between instructions freezes PC with no side effects. Re-raising RUN resumes at the held PC.

Test Plan:
- Reset then RUN=1 with RAM holding 4 non-branch words then 0x0000 → ADDR sequence 00,02,04,06,08 then holds 08. HALTED=1 from the cycle after ADDR=08 is seen. RETIRED=4. ADV never asserted at 08.
- BNE backward: PC=0x22, INSTR=16'b1001000111111000, RS_DATA=0, RT_DATA=5, RUN=1 → BR_TAKEN=1, next ADDR=0x12. With RT_DATA=0 → next ADDR=0x24.
- BGEZ forward: PC=0x3E, INSTR=16'b1010100000010111, RS_DATA=16'h7FFF → next ADDR=0x6C. With RS_DATA=16'h8000 → 0x40. BLTZ at 0x6E with offset +2 and RS_DATA=16'hFFF9 → 0x72.
- Single-step: RUN=0, STEP held high 5 cycles then low, then pulsed once → exactly two advances, RETIRED=2, ADV high for exactly one cycle per STEP rising edge.
- Wrap and saturation:
  - PC=0xFE, non-branch INSTR, RUN=1 → ADDR=0x00.
  - Preset RETIRED near max (CNT_W=4 build): after 20 ADV cycles RETIRED=4'hF.
- Reset mid-run and while halted: assert RESET for 1 cycle during a taken branch → ADDR=PC_RESET next cycle, ADV=0 during RESET. HALTED=1 then RESET → HALTED=0, RETIRED=0, execution restarts at 0x00.
